// File: rtl/interconnect_link_arbiter.sv
// interconnect_link_arbiter: round-robin merge of all physical planes of an
// interconnect link bundle onto one local link through a one-entry registered
// output stage. A saturating counter records cycles with contending requests.
//
// Link widths come from the interconnect configuration macros. Defaults are
// provided here so the block elaborates on its own.
`ifndef TIA_NUM_PHYSICAL_PLANES
`define TIA_NUM_PHYSICAL_PLANES 4
`endif
`ifndef TIA_TAG_WIDTH
`define TIA_TAG_WIDTH 8
`endif
`ifndef TIA_WORD_WIDTH
`define TIA_WORD_WIDTH 32
`endif

module interconnect_link_arbiter (
  input  logic                                                      clock,
  input  logic                                                      reset,
  // Receiver side of the plane bundle; tag/data are plane-major packed
  input  logic [`TIA_NUM_PHYSICAL_PLANES-1:0]                       input_interconnect_link_reqs,
  output logic [`TIA_NUM_PHYSICAL_PLANES-1:0]                       input_interconnect_link_acks,
  input  logic [`TIA_NUM_PHYSICAL_PLANES*`TIA_TAG_WIDTH-1:0]        input_interconnect_link_tag_lines,
  input  logic [`TIA_NUM_PHYSICAL_PLANES*`TIA_WORD_WIDTH-1:0]       input_interconnect_link_data_lines,
  // Sender side of the single outgoing link
  output logic                                                      output_link_req,
  input  logic                                                      output_link_ack,
  output logic [`TIA_TAG_WIDTH-1:0]                                 output_link_packet_tag,
  output logic [`TIA_WORD_WIDTH-1:0]                                output_link_packet_data,
  // Saturating count of cycles with two or more requests
  output logic [15:0]                                               contention_count
);

  localparam int P  = `TIA_NUM_PHYSICAL_PLANES;
  localparam int TW = `TIA_TAG_WIDTH;
  localparam int WW = `TIA_WORD_WIDTH;
  // Pointer keeps at least one bit so a single-plane build still elaborates;
  // it is then held at zero.
  localparam int PW = (P > 1) ? $clog2(P) : 1;

  logic          out_valid_q, out_valid_d;
  logic [TW-1:0] out_tag_q,   out_tag_d;
  logic [WW-1:0] out_data_q,  out_data_d;
  logic [PW-1:0] ptr_q,       ptr_d;
  logic [15:0]   cnt_q,       cnt_d;

  logic          can_accept_s;
  logic          win_found_s;
  logic [PW-1:0] win_idx_s;
  logic          xfer_s;
  logic [P-1:0]  acks_s;

  // The stage can take a word when empty or when its word drains this cycle
  assign can_accept_s = !out_valid_q || output_link_ack;

  // Round-robin search starting at ptr; the lowest rotated offset wins
  always_comb begin
    int idx;
    win_found_s = 1'b0;
    win_idx_s   = '0;
    idx         = 0;
    for (int k = P - 1; k >= 0; k--) begin
      idx = (int'(ptr_q) + k) % P;
      if (input_interconnect_link_reqs[idx]) begin
        win_found_s = 1'b1;
        win_idx_s   = idx[PW-1:0];
      end else begin
        win_found_s = win_found_s;
      end
    end
  end

  // Grant only the winner, and only when the output stage can take its word
  always_comb begin
    acks_s = '0;
    if (!reset && win_found_s) begin
      acks_s[win_idx_s] = can_accept_s;
    end else begin
      acks_s = '0;
    end
  end

  assign xfer_s = !reset && win_found_s && can_accept_s;

  // Next state of the output stage, pointer and contention counter
  always_comb begin
    out_valid_d = out_valid_q;
    out_tag_d   = out_tag_q;
    out_data_d  = out_data_q;
    ptr_d       = ptr_q;
    cnt_d       = cnt_q;

    if (xfer_s) begin
      // Fill, possibly in the same cycle as a drain
      out_valid_d = 1'b1;
      out_tag_d   = input_interconnect_link_tag_lines[win_idx_s*TW +: TW];
      out_data_d  = input_interconnect_link_data_lines[win_idx_s*WW +: WW];
      if ((P == 1) || (int'(win_idx_s) == P - 1)) begin
        ptr_d = '0;
      end else begin
        ptr_d = win_idx_s + PW'(1);
      end
    end else if (out_valid_q && output_link_ack) begin
      // Drain only; tag and data keep their last value
      out_valid_d = 1'b0;
    end else begin
      out_valid_d = out_valid_q;
    end

    if (($countones(input_interconnect_link_reqs) >= 2) && (cnt_q != 16'hFFFF)) begin
      cnt_d = cnt_q + 16'd1;
    end else begin
      cnt_d = cnt_q;
    end
  end

  // State registers with synchronous active-high reset
  always_ff @(posedge clock) begin
    if (reset) begin
      out_valid_q <= 1'b0;
      out_tag_q   <= '0;
      out_data_q  <= '0;
      ptr_q       <= '0;
      cnt_q       <= 16'h0000;
    end else begin
      out_valid_q <= out_valid_d;
      out_tag_q   <= out_tag_d;
      out_data_q  <= out_data_d;
      ptr_q       <= ptr_d;
      cnt_q       <= cnt_d;
    end
  end

  assign input_interconnect_link_acks = acks_s;
  assign output_link_req              = out_valid_q;
  assign output_link_packet_tag       = out_tag_q;
  assign output_link_packet_data      = out_data_q;
  assign contention_count             = cnt_q;

endmodule
